// File: rtl/adc_sample_capture.sv
// -----------------------------------------------------------------------------
// adc_sample_capture
//   Receive end of the 4-bit ADC interface. The raw code (d3..d0) is
//   registered every clock, blocks of 2^AVG_LOG2 enabled samples are summed
//   and truncated to an average, and the averages are queued in a small
//   first-word-fall-through FIFO with a valid/ready output.
//
// Optional feature (macro ADC_CAPTURE_MINMAX_EN):
//   When defined, code_min/code_max track the smallest/largest raw code seen
//   on enabled edges since reset or clear. When undefined, both ports are
//   tied to zero and no tracking logic exists.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         capture enable (low discards any partial block)
//   clear      synchronous flush: FIFO, accumulator, overflow, min/max
//   adc_code   raw ADC code, bit i = d_i
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head word
//   out_data   head word (holds last popped value while empty)
//   level      FIFO occupancy
//   overflow   sticky flag: an average was dropped because the FIFO was full
//   code_min   minimum raw code captured (optional feature)
//   code_max   maximum raw code captured (optional feature)
// -----------------------------------------------------------------------------
module adc_sample_capture #(
  parameter int CODE_W   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [CODE_W-1:0]        adc_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CODE_W-1:0]        code_min,
  output logic [CODE_W-1:0]        code_max
);

  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [CODE_W-1:0] code_q;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [CODE_W-1:0] last_q, last_d;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] avg;
  logic              push, pop, full, wr_en;

  // Sum including the current sample; the final sum of a block never exceeds
  // 2^AVG_LOG2 * (2^CODE_W - 1), so ACC_W bits cannot overflow.
  assign acc_sum = acc_q + ACC_W'(code_q);
  assign avg     = acc_sum[ACC_W-1:AVG_LOG2];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign out_valid = (level != '0);
  assign full      = (level == PW'(DEPTH));
  assign push      = en && !clear && (cnt_q == CNT_LAST);
  assign pop       = out_valid && out_ready && !clear;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en     = push && (!full || pop);

  assign out_data  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : last_q;
  assign overflow  = overflow_q;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    last_d     = last_q;
    if (clear) begin
      acc_d      = '0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
      last_d     = '0;
    end else begin
      if (!en || (cnt_q == CNT_LAST)) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (push && !wr_en) overflow_d = 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        last_d   = mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      code_q     <= adc_code;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  // Storage is only read while occupied, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= avg;
  end

`ifdef ADC_CAPTURE_MINMAX_EN
  logic [CODE_W-1:0] code_min_q, code_min_d, code_max_q, code_max_d;

  always_comb begin
    code_min_d = code_min_q;
    code_max_d = code_max_q;
    if (clear) begin
      code_min_d = '1;
      code_max_d = '0;
    end else if (en) begin
      if (code_q < code_min_q) code_min_d = code_q;
      if (code_q > code_max_q) code_max_d = code_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_min_q <= '1;
      code_max_q <= '0;
    end else begin
      code_min_q <= code_min_d;
      code_max_q <= code_max_d;
    end
  end

  assign code_min = code_min_q;
  assign code_max = code_max_q;
`else
  assign code_min = '0;
  assign code_max = '0;
`endif

endmodule
